// File: rtl/typing_pkg.sv
// Shared constants and state encoding for the typing scorer.
// Key codes and the centisecond cap are common to the engine and its test bench.
package typing_pkg;

    localparam logic [4:0]  KEY_BACK   = 5'd27;
    localparam logic [4:0]  KEY_SPACE  = 5'd28;
    localparam int unsigned CENTIS_CAP = 18000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/typing_scorer_seq_divider.sv
// Restoring divider: 2W-bit dividend over W-bit divisor, one quotient bit per cycle.
// The dividend high half preloads the remainder; if it already reaches the divisor the quotient saturates.
module seq_divider #(
    parameter int W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             start,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [W-1:0]     quotient
);

    localparam int CW = $clog2(W + 1);

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dz_q, dz_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dsr_q, dsr_d;
    logic [W:0]    trial_s;

    // Load, iterate and finish control for one division
    always_comb begin
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        trial_s = {rem_q, quo_q[W-1]} - {1'b0, dsr_q};
        if (clr) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start && !busy_q) begin
            busy_d = 1'b1;
            cnt_d  = CW'(W);
            rem_d  = dividend[2*W-1:W];
            quo_d  = dividend[W-1:0];
            dsr_d  = divisor;
            dz_d   = (divisor == '0);
            ovf_d  = (divisor != '0) && (dividend[2*W-1:W] >= divisor);
        end else if (busy_q) begin
            // A borrow in the top bit means the trial subtraction went negative
            if (!trial_s[W]) begin
                rem_d = trial_s[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = {rem_q[W-2:0], quo_q[W-1]};
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Divider state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            dz_q   <= dz_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dsr_q  <= dsr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign quotient = dz_q ? '0 : (ovf_q ? '1 : quo_q);

endmodule

// File: rtl/typing_scorer.sv
// Per-round typing engine: word buffer and cursor, commit scoring against the host target,
// 10 ms round timer, and end-of-round accuracy/WPM through one shared serial divider.
module typing_scorer
    import typing_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int CHAR_W   = 5,
    parameter int TICK_DIV = 1000000,
    parameter int CNT_W    = 16,
    parameter int LIM_W    = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         mode,
    input  logic [LIM_W-1:0]             target_limit,
    input  logic                         key_valid,
    input  logic [CHAR_W-1:0]            key_code,
    input  logic [MAX_LEN*CHAR_W-1:0]    target_word,
    input  logic [$clog2(MAX_LEN+1)-1:0] target_len,
    output logic                         word_req,
    output logic [LIM_W-1:0]             word_idx,
    output logic [MAX_LEN*CHAR_W-1:0]    typed,
    output logic [$clog2(MAX_LEN+1)-1:0] cursor,
    output logic [14:0]                  centis,
    output logic [CNT_W-1:0]             words_done,
    output logic [CNT_W-1:0]             typed_total,
    output logic [CNT_W-1:0]             correct_total,
    output logic [6:0]                   acc,
    output logic [9:0]                   wpm,
    output logic                         busy,
    output logic                         done
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int BUF_W = MAX_LEN * CHAR_W;
    localparam int DIV_W = CNT_W + 8;
    localparam int PRE_W = $clog2(TICK_DIV + 1);
    localparam logic [14:0]      CS_CAP   = 15'(CENTIS_CAP);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [LIM_W-1:0]    lim_q, lim_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [LEN_W-1:0]    cursor_q, cursor_d;
    logic [CNT_W-1:0]    words_q, words_d;
    logic [CNT_W-1:0]    typed_tot_q, typed_tot_d;
    logic [CNT_W-1:0]    correct_q, correct_d;
    logic [LIM_W-1:0]    word_idx_q, word_idx_d;
    logic [14:0]         centis_q, centis_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                commit_q, commit_d;
    logic                word_req_q, word_req_d;
    logic [6:0]          acc_q, acc_d;
    logic [9:0]          wpm_q, wpm_d;
    logic [1:0]          ph_q, ph_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                is_letter_s;
    logic                tick_s;
    logic [14:0]         lim_cs_s;
    logic [LEN_W-1:0]    matches_s;
    logic                div_start_s;
    logic                div_clr_s;
    logic [2*DIV_W-1:0]  div_dividend_s;
    logic [DIV_W-1:0]    div_divisor_s;
    logic                div_busy_s;
    logic                div_done_s;
    logic                div_zero_s;
    logic [DIV_W-1:0]    div_quo_s;

    function automatic logic [LEN_W-1:0] count_matches(
        input logic [BUF_W-1:0] a,
        input logic [BUF_W-1:0] b,
        input logic [LEN_W-1:0] n_a,
        input logic [LEN_W-1:0] n_b
    );
        logic [LEN_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < n_a) && (LEN_W'(i) < n_b) &&
                (a[i*CHAR_W +: CHAR_W] == b[i*CHAR_W +: CHAR_W])) begin
                n = n + LEN_W'(1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[CNT_W]) begin
            return '1;
        end else begin
            return s[CNT_W-1:0];
        end
    endfunction

    seq_divider #(.W(DIV_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (div_clr_s),
        .start    (div_start_s),
        .dividend (div_dividend_s),
        .divisor  (div_divisor_s),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .div_zero (div_zero_s),
        .quotient (div_quo_s)
    );

    // Next-state, key handling, round timer and result sequencing
    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        lim_d          = lim_q;
        buf_d          = buf_q;
        cursor_d       = cursor_q;
        words_d        = words_q;
        typed_tot_d    = typed_tot_q;
        correct_d      = correct_q;
        word_idx_d     = word_idx_q;
        centis_d       = centis_q;
        pre_d          = pre_q;
        commit_d       = 1'b0;
        word_req_d     = commit_q;
        acc_d          = acc_q;
        wpm_d          = wpm_q;
        ph_d           = ph_q;
        tick_s         = 1'b0;
        div_start_s    = 1'b0;
        div_clr_s      = 1'b0;
        div_dividend_s = '0;
        div_divisor_s  = '0;
        is_letter_s    = (key_code >= CHAR_W'(1)) && (key_code <= CHAR_W'(26));
        lim_cs_s       = 15'(lim_q) * 15'd100;
        matches_s      = count_matches(buf_q, target_word, cursor_q, target_len);

        if (abort) begin
            state_d   = ST_IDLE;
            acc_d     = 7'd0;
            wpm_d     = 10'd0;
            ph_d      = 2'd0;
            div_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_d      = mode;
                        lim_d       = target_limit;
                        buf_d       = '0;
                        cursor_d    = '0;
                        words_d     = '0;
                        typed_tot_d = '0;
                        correct_d   = '0;
                        word_idx_d  = '0;
                        centis_d    = 15'd0;
                        pre_d       = '0;
                        acc_d       = 7'd0;
                        wpm_d       = 10'd0;
                        ph_d        = 2'd0;
                        state_d     = (target_limit == '0) ? ST_CALC : ST_RUN;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RUN: begin
                    if (key_valid) begin
                        if (is_letter_s) begin
                            if (cursor_q < LEN_W'(MAX_LEN)) begin
                                buf_d[cursor_q*CHAR_W +: CHAR_W] = key_code;
                                cursor_d = cursor_q + LEN_W'(1);
                            end else begin
                                cursor_d = cursor_q;
                            end
                        end else if (key_code == CHAR_W'(KEY_BACK)) begin
                            if (cursor_q != '0) begin
                                buf_d[(cursor_q - LEN_W'(1))*CHAR_W +: CHAR_W] = '0;
                                cursor_d = cursor_q - LEN_W'(1);
                            end else begin
                                cursor_d = cursor_q;
                            end
                        end else if (key_code == CHAR_W'(KEY_SPACE)) begin
                            if (cursor_q != '0) begin
                                commit_d    = 1'b1;
                                correct_d   = sat_add(correct_q, CNT_W'(matches_s));
                                typed_tot_d = sat_add(typed_tot_q, CNT_W'(cursor_q));
                                words_d     = sat_add(words_q, CNT_W'(1));
                                word_idx_d  = (word_idx_q == '1) ? word_idx_q : word_idx_q + LIM_W'(1);
                                buf_d       = '0;
                                cursor_d    = '0;
                            end else begin
                                commit_d = 1'b0;
                            end
                        end else begin
                            cursor_d = cursor_q;
                        end
                    end else begin
                        cursor_d = cursor_q;
                    end

                    if (pre_q == PRE_LAST) begin
                        pre_d    = '0;
                        tick_s   = 1'b1;
                        centis_d = (centis_q == CS_CAP) ? centis_q : centis_q + 15'd1;
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end

                    // A commit landing with the expiry tick is already folded into the totals above
                    if ((tick_s && ((centis_d >= CS_CAP) || (!mode_q && (centis_d >= lim_cs_s)))) ||
                        (mode_q && commit_d && (words_d >= CNT_W'(lim_q)))) begin
                        state_d = ST_CALC;
                        ph_d    = 2'd0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_CALC: begin
                    case (ph_q)
                        2'd0: begin
                            if (!div_busy_s) begin
                                div_start_s    = 1'b1;
                                div_dividend_s = (2*DIV_W)'(correct_q) * (2*DIV_W)'(7'd100);
                                div_divisor_s  = DIV_W'(typed_tot_q);
                                ph_d           = 2'd1;
                            end else begin
                                ph_d = 2'd0;
                            end
                        end
                        2'd1: begin
                            if (div_done_s) begin
                                acc_d          = div_zero_s ? 7'd0 :
                                                 ((div_quo_s > DIV_W'(100)) ? 7'd100 : div_quo_s[6:0]);
                                div_start_s    = 1'b1;
                                div_dividend_s = (2*DIV_W)'(correct_q) * (2*DIV_W)'(11'd1200);
                                div_divisor_s  = DIV_W'(centis_q);
                                ph_d           = 2'd2;
                            end else begin
                                ph_d = 2'd1;
                            end
                        end
                        2'd2: begin
                            if (div_done_s) begin
                                wpm_d   = div_zero_s ? 10'd0 :
                                          ((div_quo_s > DIV_W'(1023)) ? 10'd1023 : div_quo_s[9:0]);
                                ph_d    = 2'd0;
                                state_d = ST_DONE;
                            end else begin
                                ph_d = 2'd2;
                            end
                        end
                        default: ph_d = 2'd0;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_CALC);
        done_d = (state_d == ST_DONE);
    end

    // Engine state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            lim_q       <= '0;
            buf_q       <= '0;
            cursor_q    <= '0;
            words_q     <= '0;
            typed_tot_q <= '0;
            correct_q   <= '0;
            word_idx_q  <= '0;
            centis_q    <= 15'd0;
            pre_q       <= '0;
            commit_q    <= 1'b0;
            word_req_q  <= 1'b0;
            acc_q       <= 7'd0;
            wpm_q       <= 10'd0;
            ph_q        <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            lim_q       <= lim_d;
            buf_q       <= buf_d;
            cursor_q    <= cursor_d;
            words_q     <= words_d;
            typed_tot_q <= typed_tot_d;
            correct_q   <= correct_d;
            word_idx_q  <= word_idx_d;
            centis_q    <= centis_d;
            pre_q       <= pre_d;
            commit_q    <= commit_d;
            word_req_q  <= word_req_d;
            acc_q       <= acc_d;
            wpm_q       <= wpm_d;
            ph_q        <= ph_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign word_req      = word_req_q;
    assign word_idx      = word_idx_q;
    assign typed         = buf_q;
    assign cursor        = cursor_q;
    assign centis        = centis_q;
    assign words_done    = words_q;
    assign typed_total   = typed_tot_q;
    assign correct_total = correct_q;
    assign acc           = acc_q;
    assign wpm           = wpm_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_typing_scorer.sv
// Scoreboard bench for typing_scorer: stimulus pushes expected word/round results,
// a negedge monitor pops and compares them whenever word_req pulses or done rises.
module tb_typing_scorer;
    import typing_pkg::*;

    localparam int MAX_LEN  = 16;
    localparam int CHAR_W   = 5;
    localparam int TICK_DIV = 10;
    localparam int CNT_W    = 16;
    localparam int LIM_W    = 7;
    localparam int LEN_W    = $clog2(MAX_LEN + 1);
    localparam int TW       = MAX_LEN * CHAR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              mode = 1'b0;
    logic [LIM_W-1:0]  target_limit = '0;
    logic              key_valid = 1'b0;
    logic [CHAR_W-1:0] key_code = '0;
    logic [TW-1:0]     target_word = '0;
    logic [LEN_W-1:0]  target_len = '0;
    logic              word_req;
    logic [LIM_W-1:0]  word_idx;
    logic [TW-1:0]     typed;
    logic [LEN_W-1:0]  cursor;
    logic [14:0]       centis;
    logic [CNT_W-1:0]  words_done, typed_total, correct_total;
    logic [6:0]        acc;
    logic [9:0]        wpm;
    logic              busy, done;

    always #5 clk = ~clk;

    typing_scorer #(
        .MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W), .TICK_DIV(TICK_DIV), .CNT_W(CNT_W), .LIM_W(LIM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .target_limit(target_limit), .key_valid(key_valid), .key_code(key_code),
        .target_word(target_word), .target_len(target_len), .word_req(word_req),
        .word_idx(word_idx), .typed(typed), .cursor(cursor), .centis(centis),
        .words_done(words_done), .typed_total(typed_total), .correct_total(correct_total),
        .acc(acc), .wpm(wpm), .busy(busy), .done(done)
    );

    typedef struct {
        bit is_done;
        int words;
        int typ;
        int cor;
        int acc;
        int wpm;
        int cs;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    logic done_prev = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endtask

    function automatic logic [TW-1:0] pack_str(input string s);
        logic [TW-1:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++) v[i*CHAR_W +: CHAR_W] = CHAR_W'(s[i] - 8'd96);
        return v;
    endfunction

    task automatic key(input logic [CHAR_W-1:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = '0;
    endtask

    task automatic type_str(input string s);
        for (int i = 0; i < s.len(); i++) key(CHAR_W'(s[i] - 8'd96));
    endtask

    task automatic set_target(input string s);
        target_word = pack_str(s);
        target_len  = LEN_W'(s.len());
    endtask

    task automatic do_start(input logic m, input logic [LIM_W-1:0] lim);
        mode         = m;
        target_limit = lim;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: done low after %0d cycles", n);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_word_req"}, word_req, 1'b0);
        chk({tag, "_word_idx"}, word_idx, '0);
        chk({tag, "_typed"}, typed, '0);
        chk({tag, "_cursor"}, cursor, '0);
        chk({tag, "_centis"}, centis, '0);
        chk({tag, "_words_done"}, words_done, '0);
        chk({tag, "_typed_total"}, typed_total, '0);
        chk({tag, "_correct_total"}, correct_total, '0);
        chk({tag, "_acc"}, acc, '0);
        chk({tag, "_wpm"}, wpm, '0);
    endtask

    // Monitor: pop and compare on every word_req pulse and every rising done
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            done_prev = 1'b0;
        end else begin
            if (word_req) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word_req: got word_req=1 want no event");
                end else begin
                    e = sbq.pop_front();
                    total++;
                    if (e.is_done) begin
                        bad++;
                        $display("FAIL event_order: got word_req want done");
                    end
                    chk("word_words_done", words_done, e.words);
                    chk("word_word_idx", word_idx, e.words);
                    chk("word_typed_total", typed_total, e.typ);
                    chk("word_correct_total", correct_total, e.cor);
                end
            end
            if (done && !done_prev) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 want no event");
                end else begin
                    e = sbq.pop_front();
                    total++;
                    if (!e.is_done) begin
                        bad++;
                        $display("FAIL event_order: got done want word_req");
                    end
                    chk("done_words_done", words_done, e.words);
                    chk("done_typed_total", typed_total, e.typ);
                    chk("done_correct_total", correct_total, e.cor);
                    chk("done_acc", acc, e.acc);
                    chk("done_wpm", wpm, e.wpm);
                    chk("done_centis", centis, e.cs);
                end
            end
            done_prev = done;
        end
    end

    initial begin
        int n;
        logic [TW-1:0] exp_buf;

        repeat (3) @(posedge clk);
        #1;
        chk_zero("in_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("after_reset");

        // Round 1: "cat" vs cat, "dog" vs dig, word-count limit 2
        set_target("cat");
        do_start(1'b1, 7'd2);
        chk("r1_busy", busy, 1'b1);
        type_str("cat");
        chk("r1_cursor", cursor, 3);
        chk("r1_typed", typed, pack_str("cat"));
        sbq.push_back('{1'b0, 1, 3, 3, 0, 0, 0});
        key(KEY_SPACE);
        chk("r1_cleared", cursor, 0);
        set_target("dig");
        repeat (46) @(posedge clk);
        #1;
        type_str("dog");
        sbq.push_back('{1'b0, 2, 6, 5, 0, 0, 0});
        sbq.push_back('{1'b1, 2, 6, 5, 83, 1023, 5});
        key(KEY_SPACE);
        wait_done(200, n);
        chk("r1_calc_cycles", n, 51);
        chk("r1_busy_done", busy, 1'b0);

        // Round 2: buffer overflow, backspace and space at cursor 0, then abort
        set_target("abc");
        do_start(1'b1, 7'd5);
        exp_buf = '0;
        for (int i = 0; i < 16; i++) begin
            key(CHAR_W'(i + 1));
            exp_buf[i*CHAR_W +: CHAR_W] = CHAR_W'(i + 1);
        end
        key(CHAR_W'(26));
        chk("overflow_cursor", cursor, 16);
        chk("overflow_typed", typed, exp_buf);
        key(KEY_BACK);
        exp_buf[15*CHAR_W +: CHAR_W] = '0;
        chk("back_cursor", cursor, 15);
        chk("back_typed", typed, exp_buf);
        for (int i = 0; i < 15; i++) key(KEY_BACK);
        key(KEY_BACK);
        chk("back_at_zero_cursor", cursor, 0);
        chk("back_at_zero_typed", typed, '0);
        key(KEY_SPACE);
        repeat (3) @(posedge clk);
        #1;
        chk("space_at_zero_words", words_done, 0);
        type_str("ab");
        sbq.push_back('{1'b0, 1, 2, 2, 0, 0, 0});
        key(KEY_SPACE);
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);

        // Round 3: time limit 1 s, no keys
        do_start(1'b0, 7'd1);
        chk("restart_words", words_done, 0);
        chk("restart_typed_total", typed_total, 0);
        chk("restart_correct", correct_total, 0);
        chk("restart_word_idx", word_idx, 0);
        sbq.push_back('{1'b1, 0, 0, 0, 0, 0, 100});
        wait_done(1200, n);
        chk("r3_start_to_done", n, 1051);

        // Round 4: commit lands on the expiry tick
        set_target("a");
        do_start(1'b0, 7'd1);
        key(CHAR_W'(1));
        repeat (998) @(posedge clk);
        #1;
        sbq.push_back('{1'b0, 1, 1, 1, 0, 0, 0});
        sbq.push_back('{1'b1, 1, 1, 1, 100, 12, 100});
        key(KEY_SPACE);
        wait_done(200, n);

        // Round 5: reset in the middle of CALC
        set_target("a");
        do_start(1'b1, 7'd1);
        sbq.push_back('{1'b0, 1, 1, 1, 0, 0, 0});
        key(CHAR_W'(1));
        key(KEY_SPACE);
        repeat (35) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("calc_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_reset", busy, 1'b0);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
